// File: rtl/sdram_slot_arbiter.sv
// Single-slot SDRAM arbiter: video (port 0) first, CPU/DMA round-robin.
// Define SDRAM_ARB_STARVE_EN to let waiting low ports break port-0 runs.
module sdram_slot_arbiter #(
    parameter int DATA_PHASE   = 7,
    parameter int SLOT_LEN     = 14,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        slot_sync,
    input  logic        p0_req,
    input  logic        p0_we,
    input  logic [24:0] p0_addr,
    input  logic [7:0]  p0_din,
    input  logic        p0_aux,
    output logic        p0_ack,
    output logic [15:0] p0_dout,
    input  logic        p1_req,
    input  logic        p1_we,
    input  logic [24:0] p1_addr,
    input  logic [7:0]  p1_din,
    input  logic        p1_aux,
    output logic        p1_ack,
    output logic [15:0] p1_dout,
    input  logic        p2_req,
    input  logic        p2_we,
    input  logic [24:0] p2_addr,
    input  logic [7:0]  p2_din,
    input  logic        p2_aux,
    output logic        p2_ack,
    output logic [15:0] p2_dout,
    output logic [24:0] mem_addr,
    output logic        mem_we,
    output logic [7:0]  mem_din,
    output logic        mem_aux,
    input  logic [15:0] mem_dout
);

    localparam bit CFG_OK = (DATA_PHASE >= 1) && (DATA_PHASE <= SLOT_LEN - 3)
                         && (DATA_PHASE <= 15)
                         && (STARVE_LIMIT >= 1) && (STARVE_LIMIT <= 7);

    if (!CFG_OK) begin : g_bad_cfg
        $error("sdram_slot_arbiter: illegal DATA_PHASE/SLOT_LEN/STARVE_LIMIT");
    end

    localparam logic [3:0] DP = DATA_PHASE[3:0];

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  phase_q, phase_d;
    logic [1:0]  gnt_q, gnt_d;
    logic [1:0]  rr_last_q, rr_last_d;
    logic [2:0]  ack_q, ack_d;
    logic [15:0] dout_q [3];
    logic [15:0] dout_d [3];
    logic [24:0] mem_addr_q, mem_addr_d;
    logic        mem_we_q, mem_we_d;
    logic [7:0]  mem_din_q, mem_din_d;
    logic        mem_aux_q, mem_aux_d;

`ifdef SDRAM_ARB_STARVE_EN
    localparam logic [2:0] STARVE_MAX = STARVE_LIMIT[2:0];
    logic [2:0]  starve_q, starve_d;
`endif

    logic [2:0]  req, elig;
    logic        low_wait, force_low, win_vld;
    logic [1:0]  rr_win, win;
    logic [24:0] sel_addr;
    logic        sel_we, sel_aux;
    logic [7:0]  sel_din;

    assign req = {p2_req, p1_req, p0_req};

    // A port being acked may still show req high; it is not eligible again.
    always_comb begin
        elig = req & ~ack_q;
        for (int n = 0; n < 3; n++) begin
            if (state_q == S_BUSY && gnt_q == 2'(n)) elig[n] = 1'b0;
        end
        low_wait = elig[1] | elig[2];
        if (elig[1] && elig[2]) begin
            rr_win = (rr_last_q == 2'd1) ? 2'd2 : 2'd1;
        end else begin
            rr_win = elig[1] ? 2'd1 : 2'd2;
        end
`ifdef SDRAM_ARB_STARVE_EN
        force_low = low_wait && (starve_q >= STARVE_MAX);
`else
        force_low = 1'b0;
`endif
        win_vld = |elig;
        priority case (1'b1)
            elig[0] && !force_low: win = 2'd0;
            low_wait:              win = rr_win;
            default:               win = 2'd0;
        endcase
    end

    always_comb begin
        sel_addr = p0_addr;
        sel_we   = p0_we;
        sel_din  = p0_din;
        sel_aux  = p0_aux;
        case (win)
            2'd1: begin
                sel_addr = p1_addr;
                sel_we   = p1_we;
                sel_din  = p1_din;
                sel_aux  = p1_aux;
            end
            2'd2: begin
                sel_addr = p2_addr;
                sel_we   = p2_we;
                sel_din  = p2_din;
                sel_aux  = p2_aux;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        gnt_d      = gnt_q;
        rr_last_d  = rr_last_q;
        ack_d      = '0;
        dout_d     = dout_q;
        mem_addr_d = mem_addr_q;
        mem_we_d   = mem_we_q;
        mem_din_d  = mem_din_q;
        mem_aux_d  = mem_aux_q;
`ifdef SDRAM_ARB_STARVE_EN
        starve_d   = starve_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (slot_sync) begin
                    if (win_vld) begin
                        state_d    = S_BUSY;
                        gnt_d      = win;
                        phase_d    = '0;
                        mem_addr_d = sel_addr;
                        mem_we_d   = sel_we;
                        mem_din_d  = sel_din;
                        mem_aux_d  = sel_aux;
                        if (win != 2'd0) rr_last_d = win;
`ifdef SDRAM_ARB_STARVE_EN
                        if (win == 2'd0 && low_wait) begin
                            starve_d = (starve_q == 3'd7) ? starve_q
                                                          : starve_q + 3'd1;
                        end else begin
                            starve_d = '0;
                        end
`endif
                    end else begin
                        // Nobody wants this slot: let it be a dummy read.
                        mem_we_d = 1'b0;
`ifdef SDRAM_ARB_STARVE_EN
                        starve_d = '0;
`endif
                    end
                end
            end
            S_BUSY: begin
                phase_d = phase_q + 4'd1;
                if (phase_q == DP) begin
                    state_d = S_IDLE;
                    for (int n = 0; n < 3; n++) begin
                        if (gnt_q == 2'(n)) begin
                            ack_d[n] = 1'b1;
                            if (!mem_we_q) dout_d[n] = mem_dout;
                        end
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            phase_q    <= '0;
            gnt_q      <= '0;
            rr_last_q  <= 2'd2;
            ack_q      <= '0;
            dout_q     <= '{default: '0};
            mem_addr_q <= '0;
            mem_we_q   <= 1'b0;
            mem_din_q  <= '0;
            mem_aux_q  <= 1'b0;
`ifdef SDRAM_ARB_STARVE_EN
            starve_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            phase_q    <= phase_d;
            gnt_q      <= gnt_d;
            rr_last_q  <= rr_last_d;
            ack_q      <= ack_d;
            dout_q     <= dout_d;
            mem_addr_q <= mem_addr_d;
            mem_we_q   <= mem_we_d;
            mem_din_q  <= mem_din_d;
            mem_aux_q  <= mem_aux_d;
`ifdef SDRAM_ARB_STARVE_EN
            starve_q   <= starve_d;
`endif
        end
    end

    assign p0_ack   = ack_q[0];
    assign p1_ack   = ack_q[1];
    assign p2_ack   = ack_q[2];
    assign p0_dout  = dout_q[0];
    assign p1_dout  = dout_q[1];
    assign p2_dout  = dout_q[2];
    assign mem_addr = mem_addr_q;
    assign mem_we   = mem_we_q;
    assign mem_din  = mem_din_q;
    assign mem_aux  = mem_aux_q;

endmodule

// File: tb/tb_sdram_slot_arbiter.sv
// Bench for sdram_slot_arbiter: directed scenarios plus random slots
// checked against a per-slot arbitration model.
module tb_sdram_slot_arbiter;

    localparam int DP   = 7;
    localparam int SL   = 14;
    localparam int SLIM = 4;
`ifdef SDRAM_ARB_STARVE_EN
    localparam bit STARVE_ON = 1'b1;
`else
    localparam bit STARVE_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        slot_sync = 1'b0;
    logic [2:0]  req = '0;
    logic [2:0]  we = '0;
    logic [2:0]  aux = '0;
    logic [2:0]  ack;
    logic [24:0] addr [3];
    logic [7:0]  din [3];
    logic [15:0] dout [3];
    logic [24:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_din;
    logic        mem_aux;
    logic [15:0] mem_dout = '0;

    sdram_slot_arbiter #(
        .DATA_PHASE(DP), .SLOT_LEN(SL), .STARVE_LIMIT(SLIM)
    ) dut (
        .clk(clk), .rst_n(rst_n), .slot_sync(slot_sync),
        .p0_req(req[0]), .p0_we(we[0]), .p0_addr(addr[0]),
        .p0_din(din[0]), .p0_aux(aux[0]), .p0_ack(ack[0]), .p0_dout(dout[0]),
        .p1_req(req[1]), .p1_we(we[1]), .p1_addr(addr[1]),
        .p1_din(din[1]), .p1_aux(aux[1]), .p1_ack(ack[1]), .p1_dout(dout[1]),
        .p2_req(req[2]), .p2_we(we[2]), .p2_addr(addr[2]),
        .p2_din(din[2]), .p2_aux(aux[2]), .p2_ack(ack[2]), .p2_dout(dout[2]),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_din(mem_din),
        .mem_aux(mem_aux), .mem_dout(mem_dout)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_pass = 0;
    int          rr_last;
    int          starve;
    bit          act [3];
    logic [15:0] exp_dout [3];
    logic [24:0] exp_addr;
    bit          force_en = 1'b0;
    logic [15:0] force_val = '0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic model_reset();
        rr_last  = 2;
        starve   = 0;
        exp_addr = '0;
        for (int n = 0; n < 3; n++) begin
            exp_dout[n] = '0;
            act[n]      = 1'b0;
            req[n]      = 1'b0;
        end
    endtask

    task automatic post(input int n, input bit w, input logic [24:0] a,
                        input logic [7:0] d, input bit x);
        req[n]  = 1'b1;
        we[n]   = w;
        addr[n] = a;
        din[n]  = d;
        aux[n]  = x;
        act[n]  = 1'b1;
    endtask

    task automatic post_rand(input int n);
        post(n, 1'($urandom), 25'($urandom), 8'($urandom), 1'($urandom));
    endtask

    // Video first; CPU/DMA alternate; optional anti-starvation override.
    task automatic pick(output int w);
        bit low;
        int lw;
        low = act[1] || act[2];
        if (act[1] && act[2]) lw = (rr_last == 1) ? 2 : 1;
        else lw = act[1] ? 1 : 2;
        w = 3;
        if (act[0] && !(STARVE_ON && low && starve >= SLIM)) w = 0;
        else if (low) w = lw;
        if (w == 1 || w == 2) rr_last = w;
        if (w == 0 && low) starve = (starve < 7) ? starve + 1 : 7;
        else starve = 0;
        if (w < 3) exp_addr = addr[w];
    endtask

    task automatic chk_reset_outs();
        chk("rst_ack", 32'(ack), 0);
        for (int n = 0; n < 3; n++) chk("rst_dout", 32'(dout[n]), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_din", 32'(mem_din), 0);
        chk("rst_mem_aux", 32'(mem_aux), 0);
    endtask

    // One full slot starting at a negedge; obs is the port seen acking.
    task automatic do_slot(input bit [2:0] rnd, input int late, output int obs);
        int w;
        logic [15:0] cap;
        for (int n = 0; n < 3; n++) if (rnd[n] && !act[n]) post_rand(n);
        pick(w);
        obs = 3;
        cap = '0;
        slot_sync = 1'b1;
        mem_dout = 16'($urandom);
        for (int k = 1; k < SL; k++) begin
            @(negedge clk);
            if (k == 1) begin
                slot_sync = 1'b0;
                chk("mem_addr", 32'(mem_addr), 32'(exp_addr));
                if (w < 3) begin
                    chk("mem_we", 32'(mem_we), 32'(we[w]));
                    if (we[w]) begin
                        chk("mem_din", 32'(mem_din), 32'(din[w]));
                        chk("mem_aux", 32'(mem_aux), 32'(aux[w]));
                    end
                end else begin
                    chk("idle_we", 32'(mem_we), 0);
                end
                if (late < 3 && !act[late]) post_rand(late);
            end
            chk("ack", 32'(ack), (k == DP + 2 && w < 3) ? 32'(1 << w) : 0);
            if (k == DP + 2 && w < 3) begin
                chk("hold_addr", 32'(mem_addr), 32'(addr[w]));
                chk("hold_we", 32'(mem_we), 32'(we[w]));
                if (we[w]) begin
                    chk("hold_din", 32'(mem_din), 32'(din[w]));
                    chk("hold_aux", 32'(mem_aux), 32'(aux[w]));
                end else begin
                    exp_dout[w] = cap;
                end
                for (int n = 0; n < 3; n++)
                    chk("dout", 32'(dout[n]), 32'(exp_dout[n]));
                if (ack == 3'b001) obs = 0;
                else if (ack == 3'b010) obs = 1;
                else if (ack == 3'b100) obs = 2;
                req[w] = 1'b0;
                act[w] = 1'b0;
            end
            mem_dout = (force_en && k == DP + 1) ? force_val : 16'($urandom);
            if (k == DP + 1) cap = mem_dout;
        end
        @(negedge clk);
    endtask

    int obs;
    int rr_seq [6] = '{1, 2, 1, 2, 1, 2};
`ifdef SDRAM_ARB_STARVE_EN
    int st_seq [6] = '{0, 0, 0, 0, 1, 0};
`else
    int st_seq [6] = '{0, 0, 0, 0, 0, 0};
`endif

    initial begin
        for (int n = 0; n < 3; n++) begin
            addr[n] = '0;
            din[n]  = '0;
        end
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_outs();
        rst_n = 1'b1;
        @(negedge clk);

        post(1, 1'b0, 25'h000123, 8'h00, 1'b0);
        force_en = 1'b1;
        force_val = 16'hBEEF;
        do_slot(3'b000, 3, obs);
        force_en = 1'b0;
        chk("cpu_grant", 32'(obs), 1);
        chk("cpu_dout", 32'(dout[1]), 32'hBEEF);

        post(2, 1'b1, 25'h0ABCDE, 8'h5A, 1'b1);
        do_slot(3'b000, 3, obs);
        chk("dma_grant", 32'(obs), 2);
        chk("dma_dout", 32'(dout[2]), 0);

        do_slot(3'b111, 3, obs);
        chk("cont_0", 32'(obs), 0);
        do_slot(3'b000, 3, obs);
        chk("cont_1", 32'(obs), 1);
        do_slot(3'b000, 3, obs);
        chk("cont_2", 32'(obs), 2);

        for (int i = 0; i < 6; i++) begin
            do_slot(3'b110, 3, obs);
            chk("rr_seq", 32'(obs), 32'(rr_seq[i]));
        end
        do_slot(3'b000, 3, obs);

        for (int i = 0; i < 6; i++) begin
            do_slot(3'b011, 3, obs);
            chk("starve_seq", 32'(obs), 32'(st_seq[i]));
        end
        while (act[0] || act[1] || act[2]) do_slot(3'b000, 3, obs);

        do_slot(3'b000, 2, obs);
        chk("late_wait", 32'(obs), 3);
        do_slot(3'b000, 3, obs);
        chk("late_next", 32'(obs), 2);

        for (int i = 0; i < 40; i++) begin
            do_slot({1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 9) < 7)}, 3, obs);
        end

        for (int n = 0; n < 3; n++) begin
            req[n] = 1'b0;
            act[n] = 1'b0;
        end
        post(1, 1'b0, 25'h1234567, 8'h00, 1'b0);
        slot_sync = 1'b1;
        @(negedge clk);
        slot_sync = 1'b0;
        chk("mid_addr", 32'(mem_addr), 32'h1234567);
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outs();
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("rst_no_ack", 32'(ack), 0);
        end
        rst_n = 1'b1;
        model_reset();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_ack", 32'(ack), 0);
        end

        do_slot(3'b110, 3, obs);
        chk("post_rst_rr", 32'(obs), 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
